ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with input synchronisers, a glitch filter, a frame timeout and a byte FIFO. It decodes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) into bytes. Error conditions are reported as sticky flags. Decoded bytes are presented to the bus-side logic (AXI wrapper / CPU polling) through a valid/ready interface.

Parameters:
SAMPLE_DIV, 50, clk cycles per sample strobe (≥2); at 100 MHz this gives a 2 MHz sample rate.
SYNC_STAGES, 2, synchroniser flops on PS2C and PS2D (≥2).
FILTER_LEN, 4, consecutive equal samples required to change the filtered PS2C level (≥1).
FIFO_DEPTH, 8, byte FIFO entries (power of 2, ≥2).
TIMEOUT_SAMPLES, 4000, strobes without a falling edge before an in-progress frame is aborted.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
PS2_enable  in  1  receiver enable
PS2C  in  1  PS/2 clock from peripheral (asynchronous)
PS2D  in  1  PS/2 data from peripheral (asynchronous)
o_key_data  out  8  FIFO head byte (first-word-fall-through)
o_key_valid  out  1  FIFO not empty
i_key_ready  in  1  consumer accepts head byte
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held
o_error_parity  out  1  sticky parity error
o_error_frame  out  1  sticky start/stop error
o_error_timeout  out  1  sticky frame timeout
o_overflow  out  1  sticky: good byte dropped because the FIFO was full
i_error_clear  in  1  one-cycle pulse clears all four sticky flags
o_busy  out  1  FSM not in S_IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0; FIFO is empty; state is S_IDLE.
  - Divider is 0; filter history is all 1s; filtered clock is 1.
- PS2C and PS2D pass through SYNC_STAGES flops on every clk.
- Divider counts 0..SAMPLE_DIV-1 while PS2_enable=1. The strobe fires on the cycle the count equals SAMPLE_DIV-1, then the count wraps to 0.
- Filter, on each strobe:
  - Shift synced PS2C into a FILTER_LEN history.
  - The filtered level takes the new value only when all FILTER_LEN samples agree.
  - fall = filtered level 1→0, evaluated on that strobe. A low pulse shorter than FILTER_LEN strobes produces no edge.
  - Data bit = synced PS2D sampled on the strobe where fall=1.
- FSM:
  - S_IDLE: on fall, if data=0, go to S_RECEIVE with bit_cnt=0 and timer=0. If data=1, set o_error_frame and stay in S_IDLE.
  - S_RECEIVE: on fall, shift data in (LSB first), bit_cnt++, timer=0. Otherwise timer++ on each strobe.
    - When bit_cnt reaches 10 (8 data + parity + stop), go to S_CHECK.
    - When timer reaches TIMEOUT_SAMPLES, set o_error_timeout, discard the partial frame and go to S_IDLE.
  - S_CHECK: lasts one clk and does not wait for a strobe. Checks in priority order:
    - stop≠1 → o_error_frame.
    - else XOR(data, parity)≠1 → o_error_parity.
    - else push the byte to the FIFO; if the FIFO is full with no simultaneous pop, drop the byte and set o_overflow.
    - Always return to S_IDLE.
- Latency: o_key_valid rises 2 clk after the strobe that sampled the stop bit, when the FIFO was empty.
- FIFO:
  - Pop occurs when o_key_valid & i_key_ready.
  - Push and pop in the same cycle are both accepted, including when full; count is unchanged.
  - Pop when empty is ignored. o_fifo_count saturates at FIFO_DEPTH.
- Sticky flags: i_error_clear clears all four. If a set and a clear happen in the same cycle, the set wins.
- PS2_enable=0:
  - Next clk: FSM goes to S_IDLE, partial frame discarded, divider and filter returned to reset values.
  - FIFO contents and flags are retained, and the FIFO can still be drained.
- Default state encoding returns the FSM to S_IDLE.

Decomposition:
- Package ps2_pkg:
  - state localparams S_IDLE, S_RECEIVE, S_CHECK;
  - PS2_DATA_BITS=8 and PS2_FRAME_BITS=11;
  - a function computing odd parity.
- Sub-module ps2_byte_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.
- Synchroniser, filter and FSM stay in ps2_rx_fifo.

Test Plan:
Bench parameters are SAMPLE_DIV=4, FILTER_LEN=2, FIFO_DEPTH=4, TIMEOUT_SAMPLES=64, with the PS/2 clock period at 40 strobes.
1. Good frame 0x1C, parity 0, stop 1, i_key_ready=0 → o_key_valid=1, o_key_data=0x1C, count=1, no flags. Raise ready for one cycle → count=0.
2. Frames 0xF0 then 0x1C with ready=0 → count=2. Drain → bytes arrive as 0xF0 then 0x1C.
3. 0x1C with parity=1 → o_error_parity=1, count stays 0. Then stop=0 → o_error_frame=1. i_error_clear pulse → both 0.
4. Four bits sent, then PS2C held high for more than 64 strobes → o_error_timeout=1, o_busy=0. The following frame 0x5A is received correctly.
5. Five good frames (0x01..0x05) with ready=0 → count=4, o_overflow=1, head is 0x01. Drain yields 0x01..0x04.
6. 1-strobe low glitch on PS2C while idle → no state change. PS2_enable dropped mid-frame → o_busy=0 next clk and no byte pushed.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 frame constants, receiver state codes, parity helper.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECEIVE = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;

  // Parity bit value that makes the total number of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~(^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_byte_fifo
// Purpose  : Synchronous first-word-fall-through FIFO; push and pop may coincide.
// Revision : 1.0
// ============================================================================
module ps2_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_depth);
  assign count     = r_count;
  assign w_pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = push & (~full | w_pop_ok);
  assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver with glitch filter, timeout, byte FIFO.
// Revision : 1.0
// ============================================================================
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DIV      = 50,
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_SAMPLES = 4000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          PS2_enable,
  input  logic                          PS2C,
  input  logic                          PS2D,
  output logic [7:0]                    o_key_data,
  output logic                          o_key_valid,
  input  logic                          i_key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_error_parity,
  output logic                          o_error_frame,
  output logic                          o_error_timeout,
  output logic                          o_overflow,
  input  logic                          i_error_clear,
  output logic                          o_busy
);

  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  localparam int TMR_W   = $clog2(TIMEOUT_SAMPLES + 1);
  localparam int SHIFT_W = PS2_FRAME_BITS - 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_SAMPLES - 1);
  localparam logic [3:0]       c_bit_last = 4'(SHIFT_W - 1);

  logic [SYNC_STAGES-1:0] r_c_sync;
  logic [SYNC_STAGES-1:0] r_d_sync;
  logic                   w_c_synced;
  logic                   w_d_synced;

  logic [DIV_W-1:0]       r_div;
  logic                   w_strobe;

  logic [FILTER_LEN-1:0]  r_hist;
  logic [FILTER_LEN-1:0]  w_hist_next;
  logic                   r_filt;
  logic                   w_fall;

  logic [1:0]             r_state, w_state_nxt;
  logic [3:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;
  logic [SHIFT_W-1:0]     r_shift, w_shift_nxt;

  logic w_set_frame, w_set_parity, w_set_timeout, w_set_overflow;
  logic w_push, w_pop, w_fifo_full, w_fifo_empty;
  logic r_err_frame, r_err_parity, r_err_timeout, r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_sync <= '1;
      r_d_sync <= '1;
    end else begin
      r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], PS2C};
      r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], PS2D};
    end
  end

  assign w_c_synced = r_c_sync[SYNC_STAGES-1];
  assign w_d_synced = r_d_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (!PS2_enable || r_div == c_div_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_strobe = PS2_enable & (r_div == c_div_last);

  generate
    if (FILTER_LEN == 1) begin : g_hist_single
      assign w_hist_next = w_c_synced;
    end else begin : g_hist_shift
      assign w_hist_next = {r_hist[FILTER_LEN-2:0], w_c_synced};
    end
  endgenerate

  // The edge is reported on the same strobe that commits the filtered level low.
  assign w_fall = w_strobe & r_filt & (w_hist_next == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '1;
      r_filt <= 1'b1;
    end else if (!PS2_enable) begin
      r_hist <= '1;
      r_filt <= 1'b1;
    end else if (w_strobe) begin
      r_hist <= w_hist_next;
      if (w_hist_next == '1) begin
        r_filt <= 1'b1;
      end else if (w_hist_next == '0) begin
        r_filt <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_timer_nxt    = r_timer;
    w_shift_nxt    = r_shift;
    w_set_frame    = 1'b0;
    w_set_parity   = 1'b0;
    w_set_timeout  = 1'b0;
    w_set_overflow = 1'b0;
    w_push         = 1'b0;
    if (!PS2_enable) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_timer_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            if (!w_d_synced) begin
              w_state_nxt   = S_RECEIVE;
              w_bit_cnt_nxt = '0;
              w_timer_nxt   = '0;
            end else begin
              w_set_frame = 1'b1;
            end
          end
        end
        S_RECEIVE: begin
          if (w_fall) begin
            // LSB-first: after the stop bit, data sits in [7:0], parity [8], stop [9].
            w_shift_nxt   = {w_d_synced, r_shift[SHIFT_W-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            w_timer_nxt   = '0;
            if (r_bit_cnt == c_bit_last) begin
              w_state_nxt = S_CHECK;
            end
          end else if (w_strobe) begin
            if (r_timer == c_tmr_last) begin
              w_set_timeout = 1'b1;
              w_state_nxt   = S_IDLE;
              w_timer_nxt   = '0;
            end else begin
              w_timer_nxt = r_timer + TMR_W'(1);
            end
          end
        end
        S_CHECK: begin
          w_state_nxt = S_IDLE;
          if (!r_shift[SHIFT_W-1]) begin
            w_set_frame = 1'b1;
          end else if (r_shift[PS2_DATA_BITS] != ps2_odd_parity(r_shift[PS2_DATA_BITS-1:0])) begin
            w_set_parity = 1'b1;
          end else if (w_fifo_full && !w_pop) begin
            w_set_overflow = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_timer   <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_timer   <= w_timer_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_frame   <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_err_frame   <= w_set_frame    | (r_err_frame   & ~i_error_clear);
      r_err_parity  <= w_set_parity   | (r_err_parity  & ~i_error_clear);
      r_err_timeout <= w_set_timeout  | (r_err_timeout & ~i_error_clear);
      r_overflow    <= w_set_overflow | (r_overflow    & ~i_error_clear);
    end
  end

  assign w_pop = ~w_fifo_empty & i_key_ready;

  ps2_byte_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .wr_data (r_shift[PS2_DATA_BITS-1:0]),
    .pop     (w_pop),
    .rd_data (o_key_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (o_fifo_count)
  );

  assign o_key_valid     = ~w_fifo_empty;
  assign o_error_parity  = r_err_parity;
  assign o_error_frame   = r_err_frame;
  assign o_error_timeout = r_err_timeout;
  assign o_overflow      = r_overflow;
  assign o_busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Self-checking bench for ps2_rx_fifo against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int SAMPLE_DIV = 4;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       PS2_enable = 1'b0;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [7:0] o_key_data;
  logic       o_key_valid;
  logic       i_key_ready = 1'b0;
  logic [2:0] o_fifo_count;
  logic       o_error_parity, o_error_frame, o_error_timeout, o_overflow;
  logic       i_error_clear = 1'b0;
  logic       o_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level reference model: expected FIFO contents and sticky flags.
  logic [7:0] q_exp[$];
  logic exp_par = 1'b0, exp_frm = 1'b0, exp_to = 1'b0, exp_ovf = 1'b0;

  ps2_rx_fifo #(
    .SAMPLE_DIV      (SAMPLE_DIV),
    .SYNC_STAGES     (2),
    .FILTER_LEN      (2),
    .FIFO_DEPTH      (DEPTH),
    .TIMEOUT_SAMPLES (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .PS2_enable      (PS2_enable),
    .PS2C            (PS2C),
    .PS2D            (PS2D),
    .o_key_data      (o_key_data),
    .o_key_valid     (o_key_valid),
    .i_key_ready     (i_key_ready),
    .o_fifo_count    (o_fifo_count),
    .o_error_parity  (o_error_parity),
    .o_error_frame   (o_error_frame),
    .o_error_timeout (o_error_timeout),
    .o_overflow      (o_overflow),
    .i_error_clear   (i_error_clear),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    clks(n * SAMPLE_DIV);
  endtask

  // Sends the first nbits of an 11-bit frame, 40 strobes per PS/2 clock period.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      PS2D = bits[i];
      strobes(10);
      PS2C = 1'b0;
      strobes(20);
      PS2C = 1'b1;
      strobes(10);
    end
    PS2D = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    send_bits({stop, par, data, 1'b0}, 11);
    if (stop !== 1'b1)
      exp_frm = 1'b1;
    else if (($countones({data, par}) % 2) != 1)
      exp_par = 1'b1;
    else if (q_exp.size() == DEPTH)
      exp_ovf = 1'b1;
    else
      q_exp.push_back(data);
  endtask

  function automatic logic good_par(input logic [7:0] data);
    return ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(o_fifo_count), 32'(q_exp.size()));
    chk({tag, ".valid"}, 32'(o_key_valid), 32'(q_exp.size() != 0));
    if (q_exp.size() != 0) chk({tag, ".head"}, 32'(o_key_data), 32'(q_exp[0]));
    chk({tag, ".perr"}, 32'(o_error_parity), 32'(exp_par));
    chk({tag, ".ferr"}, 32'(o_error_frame), 32'(exp_frm));
    chk({tag, ".terr"}, 32'(o_error_timeout), 32'(exp_to));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(exp_ovf));
    chk({tag, ".busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic pop_one(input string tag);
    int k;
    k = 0;
    while (!o_key_valid && k < 50) begin
      clks(1);
      k++;
    end
    chk({tag, ".pop_valid"}, 32'(o_key_valid), 32'd1);
    chk({tag, ".pop_data"}, 32'(o_key_data), 32'(q_exp[0]));
    i_key_ready = 1'b1;
    clks(1);
    i_key_ready = 1'b0;
    void'(q_exp.pop_front());
  endtask

  task automatic clear_flags();
    i_error_clear = 1'b1;
    clks(1);
    i_error_clear = 1'b0;
    {exp_par, exp_frm, exp_to, exp_ovf} = '0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rbad;
    logic       rstop;

    // Reset state
    clks(3);
    chk("rst.data", 32'(o_key_data), 32'd0);
    check_all("rst");
    reset = 1'b1;
    clks(2);
    PS2_enable = 1'b1;
    strobes(4);

    // 1: single good frame, then one-cycle pop
    send_frame(8'h1C, 1'b0, 1'b1);
    check_all("t1");
    pop_one("t1");
    chk("t1.count_after", 32'(o_fifo_count), 32'd0);

    // 2: two frames held, drained in order
    send_frame(8'hF0, good_par(8'hF0), 1'b1);
    send_frame(8'h1C, good_par(8'h1C), 1'b1);
    check_all("t2");
    pop_one("t2a");
    pop_one("t2b");
    check_all("t2.drained");

    // 3: parity error, framing error, clear
    send_frame(8'h1C, 1'b1, 1'b1);
    check_all("t3.par");
    send_frame(8'h1C, 1'b0, 1'b0);
    check_all("t3.frm");
    clear_flags();
    check_all("t3.clr");

    // 4: truncated frame times out, next frame still decodes
    send_bits(11'b000_0000_0100, 4);
    chk("t4.busy_mid", 32'(o_busy), 32'd1);
    strobes(TIMEOUT + 10);
    exp_to = 1'b1;
    check_all("t4.to");
    send_frame(8'h5A, good_par(8'h5A), 1'b1);
    check_all("t4.5a");
    pop_one("t4");
    clear_flags();

    // 5: overflow on fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), good_par(8'(i)), 1'b1);
    check_all("t5");
    for (int i = 0; i < 4; i++) pop_one("t5.drain");
    clear_flags();
    check_all("t5.done");

    // 6: one-strobe glitch while idle, then enable drop mid-frame
    PS2C = 1'b0;
    clks(SAMPLE_DIV);
    PS2C = 1'b1;
    strobes(6);
    check_all("t6.glitch");
    send_bits({2'b11, 8'hA5, 1'b0}, 5);
    chk("t6.busy_mid", 32'(o_busy), 32'd1);
    PS2_enable = 1'b0;
    clks(1);
    chk("t6.busy_off", 32'(o_busy), 32'd0);
    strobes(4);
    PS2_enable = 1'b1;
    strobes(4);
    check_all("t6.off");

    // Randomized frames against the model, with random draining and clearing
    for (int r = 0; r < 10; r++) begin
      rd    = 8'($urandom);
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 5) != 0);
      send_frame(rd, good_par(rd) ^ rbad, rstop);
      check_all("rnd");
      if ($urandom_range(0, 1) == 1 && q_exp.size() != 0) pop_one("rnd");
      if ($urandom_range(0, 3) == 0) clear_flags();
    end
    while (q_exp.size() != 0) pop_one("rnd.final");
    check_all("rnd.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
